// File: rtl/encoder_pkg.sv
// Shared encoder definitions: default filter geometry and the {a,b} quadrature state type
// used by both encoder_input_filter and quadrature_decoder.
package encoder_pkg;

  localparam int DEFAULT_SYNC_STAGES   = 2;
  localparam int DEFAULT_FILTER_CYCLES = 16;

  typedef struct packed {
    logic a;
    logic b;
  } quad_state_t;

endpackage

// File: rtl/glitch_filter.sv
// One encoder channel: metastability synchronizer followed by a persistence filter that
// only accepts a new level after it has been seen for FILTER_CYCLES consecutive clocks.
module glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 16
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_clean,
  output logic o_update,
  output logic o_reject
);

  localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_clean;
  logic                   w_sync;
  logic                   w_differ;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_differ = (w_sync != r_clean);

  // Strobes describe what the coming edge does, so the parent can register them in
  // step with r_clean.
  assign o_update = w_differ && (r_cnt == CNT_LAST);
  assign o_reject = !w_differ && (r_cnt != '0);
  assign o_clean  = r_clean;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_clean <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (o_update) begin
        r_clean <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/encoder_input_filter.sv
// Conditions raw quadrature pins into clean A/B levels, an edge strobe and a sticky
// skipped-state flag. Optional rejected-glitch counter behind `ENC_FILTER_STATS_EN.
module encoder_input_filter
  import encoder_pkg::*;
#(
  parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
  parameter int FILTER_CYCLES = DEFAULT_FILTER_CYCLES
) (
  input  logic        clk,
  input  logic        rst_raw,
  input  logic        encoder1,
  input  logic        encoder2,
  input  logic        err_clear,
  output logic        enc_a_clean,
  output logic        enc_b_clean,
  output logic        edge_valid,
  output logic        err_skip
`ifdef ENC_FILTER_STATS_EN
  ,
  output logic [15:0] glitch_count
`endif
);

  logic [1:0]  w_raw;
  logic [1:0]  w_clean;
  logic [1:0]  w_update;
  logic [1:0]  w_reject;
  quad_state_t w_state;
  logic        r_edge_valid;
  logic        r_err_skip;

  // Bit 1 is channel A, bit 0 is channel B, matching quad_state_t.
  assign w_raw = {encoder1, encoder2};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      glitch_filter #(
        .SYNC_STAGES  (SYNC_STAGES),
        .FILTER_CYCLES(FILTER_CYCLES)
      ) u_filter (
        .clk     (clk),
        .i_rst_n (rst_raw),
        .i_raw   (w_raw[gi]),
        .o_clean (w_clean[gi]),
        .o_update(w_update[gi]),
        .o_reject(w_reject[gi])
      );
    end
  endgenerate

  assign w_state     = w_clean;
  assign enc_a_clean = w_state.a;
  assign enc_b_clean = w_state.b;
  assign edge_valid  = r_edge_valid;
  assign err_skip    = r_err_skip;

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw) begin
      r_edge_valid <= 1'b0;
      r_err_skip   <= 1'b0;
    end else begin
      r_edge_valid <= |w_update;
      if (&w_update)
        r_err_skip <= 1'b1;
      else if (err_clear)
        r_err_skip <= 1'b0;
    end
  end

`ifdef ENC_FILTER_STATS_EN
  logic [15:0] r_glitch_count;
  logic [1:0]  w_rej_sum;
  logic [16:0] w_gc_sum;

  assign w_rej_sum    = {1'b0, w_reject[1]} + {1'b0, w_reject[0]};
  assign w_gc_sum     = {1'b0, r_glitch_count} + {15'b0, w_rej_sum};
  assign glitch_count = r_glitch_count;

  always_ff @(posedge clk or negedge rst_raw) begin
    if (!rst_raw)
      r_glitch_count <= '0;
    else if (err_clear)
      r_glitch_count <= '0;
    else
      r_glitch_count <= w_gc_sum[16] ? 16'hFFFF : w_gc_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_encoder_input_filter.sv
// Randomized/directed bench for encoder_input_filter with a sliding-window reference
// model feeding a scoreboard that an independent monitor drains on edge_valid.
module tb_encoder_input_filter;

  localparam int SYNC = 2;
  localparam int FILT = 4;

  logic clk = 1'b0;
  logic rst_raw = 1'b0;
  logic encoder1 = 1'b0;
  logic encoder2 = 1'b0;
  logic err_clear = 1'b0;
  logic enc_a_clean, enc_b_clean, edge_valid, err_skip;
`ifdef ENC_FILTER_STATS_EN
  logic [15:0] glitch_count;
`endif

  always #5 clk = ~clk;

  encoder_input_filter #(
    .SYNC_STAGES  (SYNC),
    .FILTER_CYCLES(FILT)
  ) dut (
    .clk        (clk),
    .rst_raw    (rst_raw),
    .encoder1   (encoder1),
    .encoder2   (encoder2),
    .err_clear  (err_clear),
    .enc_a_clean(enc_a_clean),
    .enc_b_clean(enc_b_clean),
    .edge_valid (edge_valid),
    .err_skip   (err_skip)
`ifdef ENC_FILTER_STATS_EN
    ,
    .glitch_count(glitch_count)
`endif
  );

  typedef struct {
    int edge_no;
    bit a;
    bit b;
    bit skip;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err = 0;
  int   g_edge = 0;
  int   ev_count = 0;

  // Reference state: raw samples per active edge since reset release, plus model outputs.
  bit ra[$];
  bit rb[$];
  bit m_a, m_b, m_err, in_rst;
  int m_gc;

  always @(posedge clk) g_edge <= g_edge + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, g_edge, act, exp);
    end
  endtask

  // Synchronized value seen at active edge j+SYNC is the raw sample of active edge j.
  function automatic bit samp(input bit q[$], input int j);
    return (j < 0) ? 1'b0 : q[j];
  endfunction

  // Accept when the last FILT synchronized samples all disagree with the held level.
  function automatic bit accepts(input bit q[$], input bit cl, input int k);
    if (k - FILT + 1 < 0) return 1'b0;
    for (int j = k - SYNC - FILT + 1; j <= k - SYNC; j++)
      if (samp(q, j) == cl) return 1'b0;
    return 1'b1;
  endfunction

  // A glitch ends when the synchronized level just disagreed and now agrees again.
  function automatic bit rejects(input bit q[$], input bit cl, input int k);
    if (k < 1) return 1'b0;
    return (samp(q, k - SYNC) == cl) && (samp(q, k - 1 - SYNC) != cl);
  endfunction

  task automatic model_edge(input bit a, input bit b, input bit clr);
    int k;
    bit ua, ub, ja, jb;
    k = ra.size();
    ra.push_back(a);
    rb.push_back(b);
    ua = accepts(ra, m_a, k);
    ub = accepts(rb, m_b, k);
    ja = rejects(ra, m_a, k);
    jb = rejects(rb, m_b, k);
    if (ua) m_a = ~m_a;
    if (ub) m_b = ~m_b;
    if (ua && ub) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
    if (ua || ub) sb.push_back('{g_edge + 1, m_a, m_b, m_err});
    if (clr) m_gc = 0;
    else m_gc = (m_gc + int'(ja) + int'(jb) > 65535) ? 65535 : m_gc + int'(ja) + int'(jb);
  endtask

  task automatic model_reset();
    in_rst = 1'b1;
    ra.delete();
    rb.delete();
    m_a = 1'b0;
    m_b = 1'b0;
    m_err = 1'b0;
    m_gc = 0;
  endtask

  task automatic step(input bit a, input bit b, input bit clr);
    bit stale;
    @(negedge clk);
    encoder1 = a;
    encoder2 = b;
    err_clear = clr;
    if (!in_rst) model_edge(a, b, clr);
    @(posedge clk);
    #1;
    check("enc_a_clean", enc_a_clean, m_a);
    check("enc_b_clean", enc_b_clean, m_b);
    check("err_skip", err_skip, m_err);
`ifdef ENC_FILTER_STATS_EN
    check("glitch_count", glitch_count, m_gc);
`endif
    stale = (sb.size() > 0) && (sb[0].edge_no < g_edge);
    check("missed_edge_valid", stale, 0);
    if (stale) void'(sb.pop_front());
  endtask

  task automatic hold(input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_enc_a", enc_a_clean, 0);
    check("rst_enc_b", enc_b_clean, 0);
    check("rst_edge_valid", edge_valid, 0);
    check("rst_err_skip", err_skip, 0);
`ifdef ENC_FILTER_STATS_EN
    check("rst_glitch_count", glitch_count, 0);
`endif
  endtask

  // Monitor: every edge_valid pulse must match the oldest predicted update.
  exp_t mon_e;
  always @(negedge clk) begin
    if (edge_valid) begin
      ev_count++;
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_edge_valid at edge %0d: got 1 expected 0", g_edge);
      end else begin
        mon_e = sb.pop_front();
        check("ev_edge_no", g_edge, mon_e.edge_no);
        check("ev_a", enc_a_clean, mon_e.a);
        check("ev_b", enc_b_clean, mon_e.b);
        check("ev_skip", err_skip, mon_e.skip);
      end
    end
  end

  initial begin
    int ev_start;
    model_reset();

    // Reset held while the pins toggle.
    for (int i = 0; i < 20; i++) step(i[0], ~i[0], i[1]);
    check_reset_outputs();
    #1 rst_raw = 1'b1;
    in_rst = 1'b0;

    // Single-channel rise, then a too-short pulse on B.
    hold(1, 0, 10);
    hold(1, 1, 3);
    hold(1, 0, 10);

    // Simultaneous changes set err_skip; it holds until a one-cycle clear.
    hold(0, 0, 10);
    hold(1, 1, 10);
    step(1, 1, 1'b1);
    hold(1, 1, 3);
    hold(0, 0, 10);
    step(0, 0, 1'b1);
    hold(0, 0, 3);

    // Asynchronous reset in the middle of a pending change.
    hold(1, 0, 4);
    #2 rst_raw = 1'b0;
    model_reset();
    #1 check_reset_outputs();
    hold(1, 0, 3);
    #1 rst_raw = 1'b1;
    in_rst = 1'b0;
    hold(1, 0, 10);

    // Clean quadrature cycle.
    hold(0, 0, 20);
    ev_start = ev_count;
    hold(1, 0, 20);
    hold(1, 1, 20);
    hold(0, 1, 20);
    hold(0, 0, 20);
    check("quad_pulse_count", ev_count - ev_start, 4);

    // Random pin activity with random persistence and occasional clears.
    for (int i = 0; i < 120; i++) begin
      bit a, b;
      int n;
      a = 1'($urandom_range(0, 1));
      b = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++) step(a, b, ($urandom_range(0, 15) == 0));
    end

    hold(0, 0, 12);
    check("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
